// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared defaults and entry field widths for the CDB broadcast queue
package cdb_pkg;

   localparam int CDB_NUM_FU      = 4;
   localparam int CDB_DATA_WIDTH  = 32;
   localparam int CDB_TAG_WIDTH   = 7;
   localparam int CDB_DEPTH       = 8;

   // Entry layout: {tag, data}, tag in the upper bits
   localparam int CDB_ENTRY_TAG_W  = CDB_TAG_WIDTH;
   localparam int CDB_ENTRY_DATA_W = CDB_DATA_WIDTH;
   localparam int CDB_ENTRY_WIDTH  = CDB_ENTRY_TAG_W + CDB_ENTRY_DATA_W;

   // Index width that stays legal for a single requester
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_broadcast_queue_rr_arbiter.sv
// rtl/cdb_broadcast_queue_rr_arbiter.sv - round-robin arbiter with rotating priority pointer
module rr_arbiter
   import cdb_pkg::*;
#(
   parameter  int NUM_FU = CDB_NUM_FU,
   localparam int IDX_W  = idx_width(NUM_FU)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_FU-1:0] req,
   input  logic              enable,
   output logic [NUM_FU-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx
);

   localparam int               CW       = IDX_W + 1;
   localparam logic [CW-1:0]    NUM_FU_W = CW'(NUM_FU);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FU - 1);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CW-1:0]    cand;
   logic             found;
   logic             grant_valid;

   // Scan requesters starting at the pointer; first pending one wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = {1'b0, ptr_q} + CW'(k);
         if (cand >= NUM_FU_W) begin
            cand = cand - NUM_FU_W;
         end
         if (!found && req[cand[IDX_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
      grant_valid = found && enable;
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // Pointer moves just past the winner, only when a grant is issued
   always_comb begin
      ptr_d = ptr_q;
      if (grant_valid) begin
         ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
   end

   // Priority pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/cdb_broadcast_queue.sv
// rtl/cdb_broadcast_queue.sv - collects FU results and broadcasts them in grant order on the CDB
module cdb_broadcast_queue
   import cdb_pkg::*;
#(
   parameter  int NUM_FU     = CDB_NUM_FU,
   parameter  int DATA_WIDTH = CDB_DATA_WIDTH,
   parameter  int TAG_WIDTH  = CDB_TAG_WIDTH,
   parameter  int DEPTH      = CDB_DEPTH,
   localparam int PTR_W      = $clog2(DEPTH),
   localparam int CNT_W      = PTR_W + 1,
   localparam int IDX_W      = idx_width(NUM_FU)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_FU-1:0]            fu_done,
   input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
   output logic [NUM_FU-1:0]            fu_queued,
   output logic                         cdb_valid,
   output logic [TAG_WIDTH-1:0]         cdb_tag,
   output logic [DATA_WIDTH-1:0]        cdb_data,
   input  logic                         cdb_ready,
   output logic [CNT_W-1:0]             count
);

   typedef struct packed {
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   entry_t            wr_entry;
   entry_t            head_entry;
   logic [NUM_FU-1:0] pending_q, pending_d;
   logic [NUM_FU-1:0] queued_q, queued_d;
   logic [NUM_FU-1:0] grant;
   logic [IDX_W-1:0]  grant_idx;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop;
   logic              push;
   logic              accept;

   // A slot is available if the queue is not full or the head leaves this cycle
   assign cdb_valid = (count_q != '0);
   assign pop       = cdb_valid && cdb_ready;
   assign accept    = (count_q < DEPTH_C) || pop;
   assign push      = |grant;

   // Arbitration sees only registered pending flags, never same-cycle fu_done
   rr_arbiter #(
      .NUM_FU    (NUM_FU)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (pending_q),
      .enable    (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Capture the granted FU's tag and result; they are held stable while pending
   always_comb begin
      wr_entry.tag  = fu_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
      wr_entry.data = fu_result[grant_idx*DATA_WIDTH +: DATA_WIDTH];
   end

   // Head entry drives the bus; zeroed when the queue is empty
   always_comb begin
      head_entry = mem_q[head_q];
      cdb_tag    = cdb_valid ? head_entry.tag  : '0;
      cdb_data   = cdb_valid ? head_entry.data : '0;
   end

   assign fu_queued = queued_q;
   assign count     = count_q;

   // Next-state for pending flags, acknowledgements, pointers, occupancy and storage
   always_comb begin
      pending_d = (pending_q & ~grant) | fu_done;
      queued_d  = grant;
      head_d    = pop  ? head_q + 1'b1 : head_q;
      tail_d    = push ? tail_q + 1'b1 : tail_q;
      count_d   = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      mem_d = mem_q;
      if (push) begin
         mem_d[tail_q] = wr_entry;
      end
   end

   // Control state; reset wins over any grant, pop or completion
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         queued_q  <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         queued_q  <= queued_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   // Entry storage; contents are meaningless outside the occupied window
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_cdb_broadcast_queue.sv
// tb/tb_cdb_broadcast_queue.sv - self-checking bench for cdb_broadcast_queue
module tb_cdb_broadcast_queue;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 7;
   localparam int D  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    fu_done;
   logic [N*TW-1:0] fu_tag;
   logic [N*DW-1:0] fu_result;
   logic [N-1:0]    fu_queued;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic            cdb_ready;
   logic [3:0]      count;

   cdb_broadcast_queue #(
      .NUM_FU     (N),
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .DEPTH      (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fu_done   (fu_done),
      .fu_tag    (fu_tag),
      .fu_result (fu_result),
      .fu_queued (fu_queued),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_ready (cdb_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } ent_t;

   typedef struct {
      bit            r;
      logic [N-1:0]  d;
      bit            rdy;
      int            c;
      bit            v;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic [N-1:0]  q;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a plain FIFO of results, pending set and rotating pointer
   ent_t         mq[$];
   bit [N-1:0]   m_pend;
   int           m_ptr;
   bit [N-1:0]   m_queued;
   bit           model_chk;
   bit           fresh_tags;
   int           next_tag;
   int           dut_pops;
   bit           cur_r;
   logic [N-1:0] cur_d;
   bit           cur_rdy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input logic [N-1:0] d, input bit rdy);
      cur_r = r; cur_d = d; cur_rdy = rdy;
      rst = r; fu_done = d; cdb_ready = rdy;
      for (int i = 0; i < N; i++) begin
         if (fresh_tags && d[i] && !m_pend[i]) begin
            fu_tag[i*TW +: TW]    = TW'(next_tag);
            fu_result[i*DW +: DW] = $urandom;
            next_tag++;
         end
      end
      #1;
      if (cdb_valid === 1'b1 && rdy) dut_pops++;
   endtask

   task automatic check_model();
      ent_t h;
      h = '0;
      if (mq.size() != 0) h = mq[0];
      check("count", count, mq.size());
      check("cdb_valid", cdb_valid, mq.size() != 0);
      check("cdb_tag", cdb_tag, h.tag);
      check("cdb_data", cdb_data, h.data);
      check("fu_queued", fu_queued, m_queued);
   endtask

   task automatic advance();
      int   g;
      bit   pop;
      ent_t e;
      pop = (mq.size() != 0) && cur_rdy;
      g = -1;
      if (mq.size() < D || pop) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      if (cur_r) begin
         mq.delete();
         m_pend   = '0;
         m_ptr    = 0;
         m_queued = '0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (g >= 0) begin
            e.tag  = fu_tag[g*TW +: TW];
            e.data = fu_result[g*DW +: DW];
            mq.push_back(e);
            m_pend[g] = 1'b0;
            m_ptr     = (g + 1) % N;
            m_queued  = N'(1) << g;
         end else begin
            m_queued = '0;
         end
         m_pend |= cur_d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit r, input logic [N-1:0] d, input bit rdy);
      drive(r, d, rdy);
      if (model_chk) check_model();
      advance();
   endtask

   vec_t         tbl[12];
   int           issued;
   int           pops0;
   logic [N-1:0] dd;
   bit [N-1:0]   p_save;

   initial begin
      fu_tag = '0; fu_result = '0; fu_done = '0; cdb_ready = 1'b0; rst = 1'b1;
      model_chk = 1'b0; fresh_tags = 1'b0; next_tag = 1; dut_pops = 0;
      m_pend = '0; m_ptr = 0; m_queued = '0;
      cycle(1'b1, '0, 1'b0);
      cycle(1'b1, '0, 1'b0);
      model_chk = 1'b1;

      // Directed table: single result, then all four FUs at once after a pointer reset
      for (int i = 0; i < N; i++) begin
         fu_tag[i*TW +: TW]    = (i == 2) ? 7'h15 : TW'(8'h10 + i);
         fu_result[i*DW +: DW] = (i == 2) ? 32'hDEADBEEF : 32'hA000 + i;
      end
      tbl[0]  = '{0, 4'b0100, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      tbl[1]  = '{0, 4'b0000, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      tbl[2]  = '{0, 4'b0000, 1, 1, 1, 7'h15, 32'hDEADBEEF, 4'b0100};
      tbl[3]  = '{0, 4'b0000, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      tbl[4]  = '{1, 4'b0000, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      tbl[5]  = '{0, 4'b1111, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      tbl[6]  = '{0, 4'b0000, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      tbl[7]  = '{0, 4'b0000, 1, 1, 1, 7'h10, 32'hA000,     4'b0001};
      tbl[8]  = '{0, 4'b0000, 1, 1, 1, 7'h11, 32'hA001,     4'b0010};
      tbl[9]  = '{0, 4'b0000, 1, 1, 1, 7'h15, 32'hDEADBEEF, 4'b0100};
      tbl[10] = '{0, 4'b0000, 1, 1, 1, 7'h13, 32'hA003,     4'b1000};
      tbl[11] = '{0, 4'b0000, 1, 0, 0, 7'h00, 32'h0,        4'b0000};
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].d, tbl[i].rdy);
         check($sformatf("tbl%0d_count", i), count, tbl[i].c);
         check($sformatf("tbl%0d_valid", i), cdb_valid, tbl[i].v);
         check($sformatf("tbl%0d_tag", i), cdb_tag, tbl[i].tag);
         check($sformatf("tbl%0d_data", i), cdb_data, tbl[i].data);
         check($sformatf("tbl%0d_queued", i), fu_queued, tbl[i].q);
         advance();
      end

      // Full queue: 9 results with the consumer stalled
      fresh_tags = 1'b1;
      cycle(1'b1, '0, 1'b0);
      issued = 0;
      for (int c = 0; c < 30; c++) begin
         dd = '0;
         for (int i = 0; i < N; i++) begin
            if (!m_pend[i] && issued < 9) begin
               dd[i] = 1'b1;
               issued++;
            end
         end
         cycle(1'b0, dd, 1'b0);
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, N'(m_pend), 1'b0);
         check("full_count", count, 8);
         check("full_queued", fu_queued, 0);
         check("full_one_pending", $countones(m_pend), 1);
         advance();
      end
      p_save = m_pend;
      drive(1'b0, '0, 1'b1);
      check("pop_cycle_count", count, 8);
      advance();
      drive(1'b0, '0, 1'b0);
      check("after_pop_count", count, 8);
      check("after_pop_queued", fu_queued, p_save);
      check_model();
      advance();
      for (int c = 0; c < 12; c++) cycle(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
      check("drained_count", count, 0);
      advance();

      // Reset with five queued and two pending
      cycle(1'b0, 4'b1111, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0001, 1'b0);
      cycle(1'b0, 4'b0110, 1'b0);
      drive(1'b1, '0, 1'b1);
      check("pre_rst_count", count, 5);
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, '0, 1'b1);
         check("post_rst_count", count, 0);
         check("post_rst_valid", cdb_valid, 0);
         check("post_rst_queued", fu_queued, 0);
         advance();
      end

      // Wrap-around: 20 streaming results, consumer toggling
      issued = 0;
      pops0  = dut_pops;
      for (int c = 0; c < 100; c++) begin
         dd = '0;
         for (int i = 0; i < N; i++) begin
            if (!m_pend[i] && issued < 20 && $urandom_range(0, 1) == 1) begin
               dd[i] = 1'b1;
               issued++;
            end
         end
         cycle(1'b0, dd, c[0] == 1'b0);
      end
      check("wrap_delivered", dut_pops - pops0, 20);
      drive(1'b0, '0, 1'b0);
      check("wrap_count", count, 0);
      advance();

      // Random traffic with occasional reset and stall bursts
      for (int c = 0; c < 2000; c++) begin
         dd = N'($urandom) & ~N'(m_pend);
         cycle($urandom_range(0, 199) == 0, dd,
               ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
